// File: rtl/bcd_display_n.sv
// Multi-digit BCD seven-segment driver: load/increment value register, per-digit
// invalid flags with blinking "E". Optional leading-zero blanking via BCD_LZ_BLANK_EN.
module bcd_display_n #(
  parameter int DIGITS    = 2,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  load,
  input  logic                  inc,
  input  logic                  clr,
  output logic [7*DIGITS-1:0]   HEX,
  output logic [DIGITS-1:0]     err,
  output logic                  err_sticky,
  output logic                  wrap
);

  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

`ifdef BCD_LZ_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [4*DIGITS-1:0] r_value;
  logic                r_err_sticky;
  logic                r_wrap;
  logic [CW-1:0]       r_cnt;
  logic                r_ph;

  logic [4*DIGITS-1:0] w_inc_value;
  logic                w_roll;
  logic [7*DIGITS-1:0] w_hex;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Decimal ripple increment; the carry out of the top digit marks an all-nines roll.
  always_comb begin
    logic c;
    c           = 1'b1;
    w_inc_value = r_value;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r_value[4*i +: 4] == 4'd9) begin
          w_inc_value[4*i +: 4] = 4'd0;
        end else begin
          w_inc_value[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    w_roll = c;
  end

  always_comb begin
    err = '0;
    for (int i = 0; i < DIGITS; i++) begin
      err[i] = (r_value[4*i +: 4] > 4'd9);
    end
  end

  // Scan from the top digit down; any shown digit (valid or invalid) ends blanking.
  always_comb begin
    logic       lz;
    logic [3:0] d;
    lz    = 1'b1;
    d     = 4'd0;
    w_hex = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = r_value[4*i +: 4];
      if (d > 4'd9) begin
        w_hex[7*i +: 7] = r_ph ? SEG_BLANK : SEG_E;
        lz = 1'b0;
      end else if (LZ_EN && lz && (d == 4'd0) && (i != 0)) begin
        w_hex[7*i +: 7] = SEG_BLANK;
      end else begin
        w_hex[7*i +: 7] = seg7(d);
        lz = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_value      <= '0;
      r_err_sticky <= 1'b0;
      r_wrap       <= 1'b0;
      r_cnt        <= '0;
      r_ph         <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (load) begin
        r_value <= bcd;
      end else if (inc && (err == '0)) begin
        r_value <= w_inc_value;
        r_wrap  <= w_roll;
      end

      if (err != '0) begin
        r_err_sticky <= 1'b1;
      end else if (clr) begin
        r_err_sticky <= 1'b0;
      end

      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_ph  <= ~r_ph;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign HEX        = w_hex;
  assign err_sticky = r_err_sticky;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_bcd_display_n.sv
// Directed bench for bcd_display_n: a 2-digit instance and a 3-digit instance
// sharing clock and reset, both with a blink half-period of 4 cycles.
module tb_bcd_display_n;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                         S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                         S7 = 7'b0001111, S8 = 7'b0000000,
                         S9 = 7'b0000100, SE = 7'b0110000, SB = 7'b1111111;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [7:0]  a_bcd;
  logic        a_load, a_inc, a_clr;
  logic [13:0] a_hex;
  logic [1:0]  a_err;
  logic        a_sticky, a_wrap;

  logic [11:0] b_bcd;
  logic        b_load, b_inc, b_clr;
  logic [20:0] b_hex;
  logic [2:0]  b_err;
  logic        b_sticky, b_wrap;

  int n_checks = 0;
  int n_errors = 0;
  int n_edge   = 0;

  bcd_display_n #(.DIGITS(2), .BLINK_DIV(4)) dut_a (
    .CLOCK_50(CLOCK_50), .reset(reset), .bcd(a_bcd), .load(a_load), .inc(a_inc),
    .clr(a_clr), .HEX(a_hex), .err(a_err), .err_sticky(a_sticky), .wrap(a_wrap));

  bcd_display_n #(.DIGITS(3), .BLINK_DIV(4)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset), .bcd(b_bcd), .load(b_load), .inc(b_inc),
    .clr(b_clr), .HEX(b_hex), .err(b_err), .err_sticky(b_sticky), .wrap(b_wrap));

  always #5 CLOCK_50 = ~CLOCK_50;

  // Edges since the last reset edge; blink phase for BLINK_DIV=4 is bit 2 of this.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
    if (reset) n_edge = 0;
    else       n_edge++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_bcd = '0; a_load = 0; a_inc = 0; a_clr = 0;
    b_bcd = '0; b_load = 0; b_inc = 0; b_clr = 0;
    tick(); tick();
    chk("reset_hex",    {18'd0, a_hex}, {18'd0, S0, S0});
    chk("reset_err",    {30'd0, a_err}, 32'd0);
    chk("reset_sticky", {31'd0, a_sticky}, 32'd0);
    chk("reset_wrap",   {31'd0, a_wrap}, 32'd0);
    reset = 1'b0;

    a_load = 1; a_bcd = 8'h47; tick(); a_load = 0;
    chk("load47_hex", {18'd0, a_hex}, {18'd0, S4, S7});
    chk("load47_err", {30'd0, a_err}, 32'd0);

    a_load = 1; a_bcd = 8'h29; tick(); a_load = 0;
    a_inc = 1; tick(); a_inc = 0;
    chk("inc29_hex", {18'd0, a_hex}, {18'd0, S3, S0});

    a_load = 1; a_bcd = 8'h98; tick(); a_load = 0;
    chk("load98_hex", {18'd0, a_hex}, {18'd0, S9, S8});
    a_inc = 1; tick();
    chk("inc99_hex",  {18'd0, a_hex}, {18'd0, S9, S9});
    chk("inc99_wrap", {31'd0, a_wrap}, 32'd0);
    tick();
    chk("roll_hex",  {18'd0, a_hex}, {18'd0, S0, S0});
    chk("roll_wrap", {31'd0, a_wrap}, 32'd1);
    tick(); a_inc = 0;
    chk("inc01_hex",  {18'd0, a_hex}, {18'd0, S0, S1});
    chk("inc01_wrap", {31'd0, a_wrap}, 32'd0);
    tick();
    chk("idle_wrap", {31'd0, a_wrap}, 32'd0);

    // Resynchronise blink phase, then load an invalid low digit.
    reset = 1; tick(); reset = 0;
    a_load = 1; a_bcd = 8'h3C; tick(); a_load = 0;
    chk("err3c_err",       {30'd0, a_err}, 32'd1);
    chk("err3c_sticky_lag", {31'd0, a_sticky}, 32'd0);
    chk("err3c_hex",       {18'd0, a_hex}, {18'd0, S3, SE});
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("blink_hex", {18'd0, a_hex}, {18'd0, S3, (n_edge[2] ? SB : SE)});
      chk("blink_sticky", {31'd0, a_sticky}, 32'd1);
    end
    a_inc = 1; tick(); a_inc = 0;
    chk("inc_ignored_hex1", {25'd0, a_hex[13:7]}, {25'd0, S3});
    chk("inc_ignored_err",  {30'd0, a_err}, 32'd1);
    chk("inc_ignored_wrap", {31'd0, a_wrap}, 32'd0);
    a_clr = 1; tick(); a_clr = 0;
    chk("clr_with_err", {31'd0, a_sticky}, 32'd1);
    a_load = 1; a_bcd = 8'h12; tick(); a_load = 0;
    chk("load12_hex", {18'd0, a_hex}, {18'd0, S1, S2});
    chk("load12_err", {30'd0, a_err}, 32'd0);
    a_clr = 1; tick(); a_clr = 0;
    chk("clr_sticky", {31'd0, a_sticky}, 32'd0);

    a_load = 1; a_bcd = 8'h22; tick();
    a_inc = 1; a_bcd = 8'h50; tick(); a_load = 0; a_inc = 0;
    chk("load_wins_hex", {18'd0, a_hex}, {18'd0, S5, S0});

    a_load = 1; a_bcd = 8'h3C; tick(); a_load = 0;
    tick(); tick(); tick(); tick(); tick();
    reset = 1; tick(); reset = 0;
    chk("midblink_reset_hex",    {18'd0, a_hex}, {18'd0, S0, S0});
    chk("midblink_reset_err",    {30'd0, a_err}, 32'd0);
    chk("midblink_reset_sticky", {31'd0, a_sticky}, 32'd0);
    chk("midblink_reset_wrap",   {31'd0, a_wrap}, 32'd0);

    b_load = 1; b_bcd = 12'h007; tick(); b_load = 0;
`ifdef BCD_LZ_BLANK_EN
    chk("lz007_hex", {11'd0, b_hex}, {11'd0, SB, SB, S7});
`else
    chk("lz007_hex", {11'd0, b_hex}, {11'd0, S0, S0, S7});
`endif
    b_load = 1; b_bcd = 12'h000; tick(); b_load = 0;
`ifdef BCD_LZ_BLANK_EN
    chk("lz000_hex", {11'd0, b_hex}, {11'd0, SB, SB, S0});
`else
    chk("lz000_hex", {11'd0, b_hex}, {11'd0, S0, S0, S0});
`endif
    b_load = 1; b_bcd = 12'h070; tick(); b_load = 0;
`ifdef BCD_LZ_BLANK_EN
    chk("lz070_hex", {11'd0, b_hex}, {11'd0, SB, S7, S0});
`else
    chk("lz070_hex", {11'd0, b_hex}, {11'd0, S0, S7, S0});
`endif
    b_load = 1; b_bcd = 12'h0A0; tick(); b_load = 0;
`ifdef BCD_LZ_BLANK_EN
    chk("lz0a0_hex", {11'd0, b_hex}, {11'd0, SB, (n_edge[2] ? SB : SE), S0});
`else
    chk("lz0a0_hex", {11'd0, b_hex}, {11'd0, S0, (n_edge[2] ? SB : SE), S0});
`endif
    chk("lz0a0_err", {29'd0, b_err}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
